// File: rtl/fetch_prefetch_unit.sv
// RV32I fetch stage with a decoupled prefetch queue.
// Sequential word fetches are issued under a credit rule that reserves queue space
// for every in-flight request. Returned words are paired with their PCs and buffered
// in a small FIFO for decode. A flush or branch redirect empties the queue. It also
// marks every still-unreturned response for discard, so decode never sees a stale PC.
// Handshakes: a memory request transfers when o_mem_req & i_mem_gnt. A decode
// transfer happens when o_inst_valid & !i_stall. Both use strict valid/ready rules.
// Valid is never withdrawn by the producer except on redirect or reset, and data is
// held stable while valid and not taken.
module fetch_prefetch_unit #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          QUEUE_DEPTH     = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_flush_sig,
   input  logic [31:0] i_flush_data,
   input  logic        i_branch_sig,
   input  logic [31:0] i_branch_data,
   input  logic        i_stall,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   input  logic        i_mem_gnt,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata,
   output logic        o_inst_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_pc
);

   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
   localparam int SW = CW + 1;

   logic          r_run;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_resp_pc;
   logic [OW-1:0] r_outst;
   logic [OW-1:0] r_discard;
   logic [31:0]   r_q_inst [QUEUE_DEPTH];
   logic [31:0]   r_q_pc   [QUEUE_DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic          w_redirect;
   logic [31:0]   w_sel;
   logic [31:0]   w_target;
   logic          w_credit;
   logic          w_hs;
   logic          w_resp;
   logic          w_drop;
   logic          w_push;
   logic          w_pop;

   assign w_redirect = i_flush_sig | i_branch_sig;
   assign w_sel      = i_flush_sig ? i_flush_data : i_branch_data;
   assign w_target   = w_sel & 32'hFFFF_FFFC;

   // Every in-flight request owns a queue slot, so a response can never overflow.
   assign w_credit = (r_outst < OW'(MAX_OUTSTANDING)) &&
                     ((SW'(r_count) + SW'(r_outst)) < SW'(QUEUE_DEPTH));

   // r_run keeps the request line low during the first cycle after reset.
   assign o_mem_req  = r_run & ~w_redirect & w_credit;
   assign o_mem_addr = r_fetch_pc;
   assign w_hs       = o_mem_req & i_mem_gnt;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign w_resp = i_mem_rvalid & (r_outst != '0);
   assign w_drop = w_resp & (r_discard != '0);
   assign w_push = w_resp & ~w_drop & ~w_redirect;
   assign w_pop  = o_inst_valid & ~i_stall & ~w_redirect;

   assign o_inst_valid = (r_count != '0);
   assign o_inst       = r_q_inst[r_rd_ptr];
   assign o_inst_pc    = r_q_pc[r_rd_ptr];

   // Fetch/response PCs, outstanding request count and discard count for squashed responses.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_run      <= 1'b0;
         r_fetch_pc <= RESET_PC;
         r_resp_pc  <= RESET_PC;
         r_outst    <= '0;
         r_discard  <= '0;
      end else begin
         r_run <= 1'b1;
         if (w_redirect) begin
            r_fetch_pc <= w_target;
            r_resp_pc  <= w_target;
            r_outst    <= r_outst - OW'(w_resp);
            r_discard  <= r_outst - OW'(w_resp);
         end else begin
            if (w_hs) begin
               r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
               r_resp_pc <= r_resp_pc + 32'd4;
            end
            r_outst <= r_outst + OW'(w_hs) - OW'(w_resp);
            if (w_drop) begin
               r_discard <= r_discard - OW'(1);
            end
         end
      end
   end

   // Prefetch FIFO. A redirect empties it. Push and pop may coincide even when full.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int k = 0; k < QUEUE_DEPTH; k++) begin
            r_q_inst[k] <= '0;
            r_q_pc[k]   <= '0;
         end
      end else if (w_redirect) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_q_inst[r_wr_ptr] <= i_mem_rdata;
            r_q_pc[r_wr_ptr]   <= r_resp_pc;
            r_wr_ptr           <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: a latency-randomised memory model plus a PC-stream scoreboard.
// Expected decode stream: every granted fetch since the last redirect or reset is delivered
// in grant order, carrying the memory word at its address.
module tb_fetch_prefetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          QD       = 4;
   localparam int          MO       = 2;

   logic        clk;
   logic        i_rst;
   logic        i_flush_sig;
   logic [31:0] i_flush_data;
   logic        i_branch_sig;
   logic [31:0] i_branch_data;
   logic        i_stall;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic        i_mem_gnt;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;
   logic        o_inst_valid;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;

   fetch_prefetch_unit #(
      .RESET_PC(RESET_PC), .QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MO)
   ) dut (
      .i_clk(clk), .i_rst(i_rst),
      .i_flush_sig(i_flush_sig), .i_flush_data(i_flush_data),
      .i_branch_sig(i_branch_sig), .i_branch_data(i_branch_data),
      .i_stall(i_stall),
      .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_gnt(i_mem_gnt),
      .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
      .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // stimulus knobs and model state
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          since_rst = 0;
   int          n_pop    = 0;
   int          gnt_pct  = 100;
   int          rv_pct   = 100;
   int          lat_max  = 0;
   logic        rst_v, stall_v, flush_v, branch_v, late_rv;
   logic [31:0] flush_d, branch_d;
   logic [31:0] pend_addr[$];
   int          pend_rdy[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_fetch;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, sample outputs mid-cycle, check and update the model.
   task automatic cycle();
      logic        redir;
      logic        hs;
      logic [31:0] tgt;
      @(negedge clk);
      i_rst         = rst_v;
      i_stall       = stall_v;
      i_flush_sig   = flush_v;
      i_flush_data  = flush_d;
      i_branch_sig  = branch_v;
      i_branch_data = branch_d;
      i_mem_gnt     = (int'($urandom_range(0, 99)) < gnt_pct);
      if (late_rv) begin
         i_mem_rvalid = 1'b1;
         i_mem_rdata  = 32'hDEAD_BEEF;
      end else if (!rst_v && pend_addr.size() > 0 && pend_rdy[0] <= cyc &&
                   int'($urandom_range(0, 99)) < rv_pct) begin
         i_mem_rvalid = 1'b1;
         i_mem_rdata  = memw(pend_addr[0]);
      end else begin
         i_mem_rvalid = 1'b0;
         i_mem_rdata  = $urandom;
      end
      #1;
      if (rst_v) begin
         pend_addr.delete();
         pend_rdy.delete();
         exp_q.delete();
         exp_fetch = RESET_PC;
         since_rst = -1;
      end else begin
         since_rst++;
         redir = flush_v | branch_v;
         tgt   = (flush_v ? flush_d : branch_d) & 32'hFFFF_FFFC;
         hs    = o_mem_req & i_mem_gnt;
         if (redir) check_eq("req_on_redirect", o_mem_req, 0);
         if (pend_addr.size() >= MO) check_eq("req_over_credit", o_mem_req, 0);
         if (o_mem_req) check_eq("fetch_addr", o_mem_addr, exp_fetch);
         if (o_inst_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("inst_unexpected", o_inst_valid, 0);
            end else begin
               check_eq("inst_pc", o_inst_pc, exp_q[0]);
               check_eq("inst_word", o_inst, memw(exp_q[0]));
               if (!stall_v && !redir) begin
                  void'(exp_q.pop_front());
                  n_pop++;
               end
            end
         end
         if (i_mem_rvalid && !late_rv) begin
            void'(pend_addr.pop_front());
            void'(pend_rdy.pop_front());
         end
         if (hs) begin
            pend_addr.push_back(o_mem_addr);
            pend_rdy.push_back(cyc + 1 + int'($urandom_range(0, lat_max)));
            exp_q.push_back(o_mem_addr);
            exp_fetch = exp_fetch + 32'd4;
         end
         if (redir) begin
            exp_q.delete();
            exp_fetch = tgt;
         end
      end
      cyc++;
   endtask

   task automatic zero_wait();
      gnt_pct = 100; rv_pct = 100; lat_max = 0;
   endtask

   task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
      bit found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle();
         if (o_inst_valid) begin
            found = 1;
            check_eq(tag, o_inst_pc, exp_pc);
         end
      end
      if (!found) check_eq({tag, "_timeout"}, o_inst_valid, 1);
   endtask

   initial begin
      rst_v = 1; stall_v = 0; flush_v = 0; branch_v = 0; late_rv = 0;
      flush_d = 0; branch_d = 0;
      i_rst = 1; i_stall = 0; i_flush_sig = 0; i_flush_data = 0;
      i_branch_sig = 0; i_branch_data = 0; i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
      exp_fetch = RESET_PC;
      zero_wait();

      // reset state
      cycle();
      cycle();
      check_eq("rst_inst_valid", o_inst_valid, 0);
      check_eq("rst_mem_req", o_mem_req, 0);
      check_eq("rst_mem_addr", o_mem_addr, RESET_PC);
      check_eq("rst_inst", o_inst, 0);
      check_eq("rst_inst_pc", o_inst_pc, 0);

      // 1: zero-wait streaming, first valid three cycles after release
      rst_v = 0;
      for (int i = 0; i < 14; i++) begin
         cycle();
         check_eq("t1_valid_timing", o_inst_valid, (since_rst >= 3));
      end

      // 2: stall fills the queue, then drain exactly QD entries with grants blocked
      stall_v = 1;
      for (int i = 0; i < 10; i++) cycle();
      check_eq("t2_req_when_full", o_mem_req, 0);
      stall_v = 0; gnt_pct = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         check_eq("t2_drain_valid", o_inst_valid, (i < QD));
      end

      // 3: branch with MAX_OUTSTANDING responses in flight
      zero_wait();
      for (int i = 0; i < 5; i++) cycle();
      rv_pct = 0;
      for (int i = 0; i < 4; i++) cycle();
      check_eq("t3_req_blocked", o_mem_req, 0);
      branch_v = 1; branch_d = 32'h0000_0100;
      cycle();
      branch_v = 0;
      zero_wait();
      wait_valid("t3_first_pc", 32'h0000_0100);
      for (int i = 0; i < 6; i++) cycle();

      // 4: flush beats branch in the same cycle, low bits forced to zero
      flush_v = 1; flush_d = 32'h0000_0202;
      branch_v = 1; branch_d = 32'h0000_0300;
      cycle();
      flush_v = 0; branch_v = 0;
      wait_valid("t4_first_pc", 32'h0000_0200);
      for (int i = 0; i < 6; i++) cycle();

      // 5: random latency, stall and redirects
      gnt_pct = 60; rv_pct = 60; lat_max = 4;
      n_pop = 0;
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         stall_v  = (int'($urandom_range(0, 99)) < 30);
         flush_v  = (r < 2);
         branch_v = (r >= 1 && r < 4);
         flush_d  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
         branch_d = $urandom;
         cycle();
      end
      flush_v = 0; branch_v = 0; stall_v = 0;
      check_eq("t5_progress", (n_pop > 200), 1);

      // 6: reset mid-stream with entries queued and requests in flight
      zero_wait();
      for (int i = 0; i < 10; i++) cycle();
      stall_v = 1;
      for (int i = 0; i < 2; i++) cycle();
      rv_pct = 0;
      for (int i = 0; i < 3; i++) cycle();
      rst_v = 1; late_rv = 1;
      cycle();
      rst_v = 0; stall_v = 0;
      cycle();
      check_eq("t6_inst_valid", o_inst_valid, 0);
      check_eq("t6_mem_req", o_mem_req, 0);
      check_eq("t6_mem_addr", o_mem_addr, RESET_PC);
      check_eq("t6_inst_pc", o_inst_pc, 0);
      late_rv = 0;
      zero_wait();
      wait_valid("t6_restart_pc", RESET_PC);
      for (int i = 0; i < 10; i++) begin
         cycle();
         check_eq("t6_stream_valid", o_inst_valid, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
